// File: rtl/flappy_pkg.sv
// Shared screen, physics and game-state definitions for the flappy bird datapath.
package flappy_pkg;
  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H     = 120;
  localparam int SPRITE_H     = 8;

  localparam int Y_WIDTH_DEF  = 7;
  localparam int Y_START_DEF  = 56;
  localparam int Y_MIN_DEF    = 0;
  localparam int Y_MAX_DEF    = SCREEN_H - SPRITE_H;
  localparam int GRAVITY_DEF  = 1;
  localparam int FLAP_VEL_DEF = -5;
  localparam int V_WIDTH_DEF  = 6;
  localparam int V_MAX_DEF    = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLYING = 2'd1,
    ST_DEAD   = 2'd2
  } state_e;
endpackage

// File: rtl/rise_edge_detect.sv
// Single-flop rising-edge detector; RST_VAL lets a level high at reset release be ignored.
module rise_edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev_q <= RST_VAL;
    else        prev_q <= sig;

  assign rise = sig & ~prev_q;
endmodule

// File: rtl/bird_physics.sv
// Frame-tick bird motion engine: flap/gravity velocity, position integration, bounds, life FSM.
// Optional build macro BIRD_TERMINAL_VEL_EN caps gravity-driven velocity at V_MAX.
module bird_physics
  import flappy_pkg::*;
#(
  parameter int Y_WIDTH  = Y_WIDTH_DEF,
  parameter int Y_START  = Y_START_DEF,
  parameter int Y_MIN    = Y_MIN_DEF,
  parameter int Y_MAX    = Y_MAX_DEF,
  parameter int GRAVITY  = GRAVITY_DEF,
  parameter int FLAP_VEL = FLAP_VEL_DEF,
  parameter int V_WIDTH  = V_WIDTH_DEF,
  parameter int V_MAX    = V_MAX_DEF
) (
  input  logic                      frameClock,
  input  logic                      resetLow,
  input  logic                      frameTick,
  input  logic                      flapBtn,
  input  logic                      startBtn,
  input  logic                      collision,
  output logic [Y_WIDTH-1:0]        birdY,
  output logic signed [V_WIDTH-1:0] birdVel,
  output logic [1:0]                state,
  output logic                      dead,
  output logic                      updateDone
);
  localparam int NUM_IN = 3;
  localparam int YW2    = Y_WIDTH + 2;

`ifdef BIRD_TERMINAL_VEL_EN
  localparam bit TERM_EN = 1'b1;
`else
  localparam bit TERM_EN = 1'b0;
`endif
  localparam logic signed [V_WIDTH:0] V_SAT = (V_WIDTH+1)'((1 << (V_WIDTH-1)) - 1);
  localparam logic signed [V_WIDTH:0] V_CAP = TERM_EN ? (V_WIDTH+1)'(V_MAX) : V_SAT;

  // Edge detectors, index 0 tick, 1 flap, 2 start; all reset high.
  logic [NUM_IN-1:0] raw_in, rise_vec;
  logic tick_r, flap_r, start_r;

  assign raw_in = {startBtn, flapBtn, frameTick};

  rise_edge_detect #(.RST_VAL(1'b1)) u_red [NUM_IN-1:0] (
    .clk   (frameClock),
    .rst_n (resetLow),
    .sig   (raw_in),
    .rise  (rise_vec)
  );

  assign tick_r  = rise_vec[0];
  assign flap_r  = rise_vec[1];
  assign start_r = rise_vec[2];

  state_e                      state_q, state_d;
  logic [Y_WIDTH-1:0]          y_q, y_d;
  logic signed [V_WIDTH-1:0]   vel_q, vel_d;
  logic                        pend_q, pend_d;
  logic                        upd_q, upd_d;
  logic                        dead_q, dead_d;

  logic                        flap_now;
  logic signed [V_WIDTH:0]     v_inc;
  logic signed [V_WIDTH-1:0]   v_grav, v_next;
  logic signed [YW2-1:0]       y_next;

  always_comb begin
    flap_now = pend_q | flap_r;
    v_inc    = {vel_q[V_WIDTH-1], vel_q} + (V_WIDTH+1)'(GRAVITY);
    v_grav   = (v_inc > V_CAP) ? V_CAP[V_WIDTH-1:0] : v_inc[V_WIDTH-1:0];
    v_next   = flap_now ? V_WIDTH'(FLAP_VEL) : v_grav;
    y_next   = $signed({2'b00, y_q}) + $signed({{(YW2-V_WIDTH){v_next[V_WIDTH-1]}}, v_next});

    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    pend_d  = pend_q;
    upd_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        y_d   = Y_WIDTH'(Y_START);
        vel_d = '0;
        upd_d = tick_r;
        // Entering flight arms a flap so the first tick launches upward.
        if (start_r || flap_r) begin
          state_d = ST_FLYING;
          pend_d  = 1'b1;
        end
      end
      ST_FLYING: begin
        if (flap_r) pend_d = 1'b1;
        if (collision) begin
          state_d = ST_DEAD;
          pend_d  = 1'b0;
        end else if (tick_r) begin
          upd_d  = 1'b1;
          pend_d = 1'b0;
          if (y_next <= YW2'(Y_MIN)) begin
            y_d   = Y_WIDTH'(Y_MIN);
            vel_d = '0;
          end else if (y_next >= YW2'(Y_MAX)) begin
            y_d     = Y_WIDTH'(Y_MAX);
            vel_d   = '0;
            state_d = ST_DEAD;
          end else begin
            y_d   = y_next[Y_WIDTH-1:0];
            vel_d = v_next;
          end
        end
      end
      ST_DEAD: begin
        if (start_r) begin
          state_d = ST_IDLE;
          y_d     = Y_WIDTH'(Y_START);
          vel_d   = '0;
          pend_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pend_d  = 1'b0;
      end
    endcase

    dead_d = (state_d == ST_DEAD);
  end

  always_ff @(posedge frameClock or negedge resetLow)
    if (!resetLow) begin
      state_q <= ST_IDLE;
      y_q     <= Y_WIDTH'(Y_START);
      vel_q   <= '0;
      pend_q  <= 1'b0;
      upd_q   <= 1'b0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      pend_q  <= pend_d;
      upd_q   <= upd_d;
      dead_q  <= dead_d;
    end

  assign birdY      = y_q;
  assign birdVel    = vel_q;
  assign state      = state_q;
  assign dead       = dead_q;
  assign updateDone = upd_q;
endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics: reset, flap arc, ceiling, terminal fall, death, collision, async reset.
module tb_bird_physics;
  logic              frameClock = 1'b0;
  logic              resetLow, frameTick, flapBtn, startBtn, collision;
  logic [6:0]        birdY;
  logic signed [5:0] birdVel;
  logic [1:0]        state;
  logic              dead, updateDone;

  always #5 frameClock = ~frameClock;

  bird_physics dut (
    .frameClock (frameClock),
    .resetLow   (resetLow),
    .frameTick  (frameTick),
    .flapBtn    (flapBtn),
    .startBtn   (startBtn),
    .collision  (collision),
    .birdY      (birdY),
    .birdVel    (birdVel),
    .state      (state),
    .dead       (dead),
    .updateDone (updateDone)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int ud_cnt;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One frame tick pulse, optionally with collision; counts updateDone pulses seen.
  task automatic tick(input bit col);
    @(negedge frameClock);
    frameTick = 1'b1;
    collision = col;
    ud_cnt    = 0;
    repeat (4) begin
      @(negedge frameClock);
      ud_cnt += int'(updateDone);
      frameTick = 1'b0;
      collision = 1'b0;
    end
  endtask

  task automatic press_flap();
    @(negedge frameClock); flapBtn = 1'b1;
    @(negedge frameClock); flapBtn = 1'b0;
    @(negedge frameClock);
  endtask

  task automatic press_start();
    @(negedge frameClock); startBtn = 1'b1;
    @(negedge frameClock); startBtn = 1'b0;
    @(negedge frameClock);
  endtask

  task automatic tick_chk(input string tag, input bit flap, input int y, input int v);
    if (flap) press_flap();
    tick(1'b0);
    chk({tag, ".y"}, int'(birdY), y);
    chk({tag, ".vel"}, int'(birdVel), v);
    chk({tag, ".ud"}, ud_cnt, 1);
  endtask

`ifdef BIRD_TERMINAL_VEL_EN
  int fall_v[12] = '{1, 2, 3, 4, 5, 6, 6, 6, 6, 6, 6, 6};
  int fall_y[12] = '{1, 3, 6, 10, 15, 21, 27, 33, 39, 45, 51, 57};
`else
  int fall_v[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
  int fall_y[12] = '{1, 3, 6, 10, 15, 21, 28, 36, 45, 55, 66, 78};
`endif
  int climb_y[11] = '{37, 33, 30, 28, 23, 19, 16, 14, 9, 5, 2};
  int climb_v[11] = '{-5, -4, -3, -2, -5, -4, -3, -2, -5, -4, -3};
  bit climb_f[11] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};

  initial begin
    resetLow  = 1'b0;
    frameTick = 1'b1;
    flapBtn   = 1'b0;
    startBtn  = 1'b0;
    collision = 1'b0;
    repeat (3) @(negedge frameClock);
    resetLow = 1'b1;
    ud_cnt   = 0;
    repeat (4) begin
      @(negedge frameClock);
      ud_cnt += int'(updateDone);
    end
    chk("rst.y", int'(birdY), 56);
    chk("rst.vel", int'(birdVel), 0);
    chk("rst.state", int'(state), 0);
    chk("rst.dead", int'(dead), 0);
    chk("rst.held_tick_ud", ud_cnt, 0);
    frameTick = 1'b0;
    tick(1'b0);
    chk("idle.tick_ud", ud_cnt, 1);
    chk("idle.tick_y", int'(birdY), 56);

    press_start();
    chk("start.state", int'(state), 1);
    tick_chk("arc0", 1'b0, 51, -5);
    tick_chk("arc1", 1'b0, 47, -4);
    tick_chk("arc2", 1'b0, 44, -3);
    tick_chk("arc3", 1'b0, 42, -2);

    for (int i = 0; i < 11; i++)
      tick_chk($sformatf("climb%0d", i), climb_f[i], climb_y[i], climb_v[i]);

    // Two presses before one tick: a single flap, yNext=-3 clamps at ceiling.
    press_flap();
    press_flap();
    tick_chk("ceil", 1'b0, 0, 0);
    chk("ceil.state", int'(state), 1);
    press_start();
    chk("fly.start_ignored", int'(state), 1);

    for (int i = 0; i < 12; i++)
      tick_chk($sformatf("fall%0d", i), 1'b0, fall_y[i], fall_v[i]);

    for (int g = 0; g < 12 && !dead; g++) tick(1'b0);
    chk("floor.ud", ud_cnt, 1);
    chk("floor.y", int'(birdY), 112);
    chk("floor.vel", int'(birdVel), 0);
    chk("floor.state", int'(state), 2);
    chk("floor.dead", int'(dead), 1);

    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      chk("dead.tick_ud", ud_cnt, 0);
      chk("dead.tick_y", int'(birdY), 112);
    end
    press_flap();
    chk("dead.flap_state", int'(state), 2);
    press_start();
    chk("restart.state", int'(state), 0);
    chk("restart.y", int'(birdY), 56);
    chk("restart.vel", int'(birdVel), 0);
    chk("restart.dead", int'(dead), 0);

    press_start();
    tick_chk("col0", 1'b0, 51, -5);
    tick_chk("col1", 1'b0, 47, -4);
    tick(1'b1);
    chk("col.ud", ud_cnt, 0);
    chk("col.state", int'(state), 2);
    chk("col.y", int'(birdY), 47);
    chk("col.dead", int'(dead), 1);

    press_start();
    press_start();
    tick_chk("mid0", 1'b0, 51, -5);
    @(negedge frameClock);
    #2 resetLow = 1'b0;
    #1;
    chk("async.y", int'(birdY), 56);
    chk("async.vel", int'(birdVel), 0);
    chk("async.state", int'(state), 0);
    @(negedge frameClock);
    resetLow = 1'b1;
    @(negedge frameClock);
    chk("async.ud", int'(updateDone), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
